// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU function encodings and the
// payload handed from decode to execute.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

  localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]   src1;
    logic [XLEN-1:0]   src2;
    logic [6:0]        funct7;
    logic [2:0]        funct3;
    logic [REG_AW-1:0] rd;
    logic              we;
  } decoded_t;

  // I-type immediate, sign-extended to the datapath width
  function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
    return {{(XLEN-12){imm[11]}}, imm};
  endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two async read ports with writeback bypass,
// one synchronous write port, x0 reads as zero.
module register_file #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned NUM_REGS  = 32,
  localparam int unsigned AW       = $clog2(NUM_REGS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AW-1:0]        rd1_addr_i,
  input  logic [AW-1:0]        rd2_addr_i,
  output logic [WORD_SIZE-1:0] rd1_data_o,
  output logic [WORD_SIZE-1:0] rd2_data_o,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i
);

  logic [WORD_SIZE-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Same-cycle writeback is forwarded so a dependent op can issue in the wb cycle
  assign rd1_data_o = (rd1_addr_i == '0) ? '0 :
                      (wr_en_i && (wr_addr_i == rd1_addr_i)) ? wr_data_i : mem_q[rd1_addr_i];
  assign rd2_data_o = (rd2_addr_i == '0) ? '0 :
                      (wr_en_i && (wr_addr_i == rd2_addr_i)) ? wr_data_i : mem_q[rd2_addr_i];

endmodule

// File: rtl/decode.sv
// Decode / operand-fetch stage for RV32 OP and OP-IMM. Reads the register file,
// tracks in-flight destinations and stalls the front end on RAW hazards.
module decode
  import riscv_pkg::*;
#(
  parameter int unsigned WORD_SIZE = XLEN,
  parameter int unsigned NUM_REGS  = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          inst_in,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  output logic [WORD_SIZE-1:0] data_source1,
  output logic [WORD_SIZE-1:0] data_source2,
  output logic [6:0]           funct7,
  output logic [2:0]           funct3,
  output logic [4:0]           reg_dest_out,
  output logic                 write_enable_out,
  output logic                 illegal_inst,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic [4:0]           wb_dest,
  input  logic                 wb_enable
);

  // Per-register in-flight count; deep enough for every write the pipeline can hold
  localparam int unsigned CNT_W = 4;

  logic [6:0]           opcode;
  logic [2:0]           f3;
  logic [REG_AW-1:0]    rs1, rs2, rd;
  logic                 is_op, is_op_imm, legal;
  logic [WORD_SIZE-1:0] rs1_val, rs2_val;
  logic                 rs1_busy, rs2_busy, stall, accept, issue_we;

  decoded_t             dec_d, dec_q;
  logic                 ill_d, ill_q;
  logic [CNT_W-1:0]     pend_d [NUM_REGS];
  logic [CNT_W-1:0]     pend_q [NUM_REGS];

  assign opcode    = inst_in[6:0];
  assign rd        = inst_in[11:7];
  assign f3        = inst_in[14:12];
  assign rs1       = inst_in[19:15];
  assign rs2       = inst_in[24:20];
  assign is_op     = (opcode == OPCODE_OP);
  assign is_op_imm = (opcode == OPCODE_OP_IMM);
  assign legal     = is_op || is_op_imm;

  register_file #(
    .WORD_SIZE (WORD_SIZE),
    .NUM_REGS  (NUM_REGS)
  ) u_regfile (
    .clock      (clock),
    .reset      (reset),
    .rd1_addr_i (rs1),
    .rd2_addr_i (rs2),
    .rd1_data_o (rs1_val),
    .rd2_data_o (rs2_val),
    .wr_en_i    (wb_enable),
    .wr_addr_i  (wb_dest),
    .wr_data_i  (wb_data)
  );

  // A source is still busy if more writes are pending than the one retiring now
  assign rs1_busy = pend_q[rs1] > CNT_W'(wb_enable && (wb_dest == rs1));
  assign rs2_busy = pend_q[rs2] > CNT_W'(wb_enable && (wb_dest == rs2));

  assign stall      = inst_valid && legal && (rs1_busy || (is_op && rs2_busy));
  assign inst_ready = !stall;
  assign accept     = inst_valid && !stall;
  assign issue_we   = accept && legal && (rd != '0);

  always_comb begin
    dec_d = '0;
    ill_d = 1'b0;
    if (accept) begin
      if (legal) begin
        dec_d.src1   = XLEN'(rs1_val);
        dec_d.src2   = is_op ? XLEN'(rs2_val) : sext12(inst_in[31:20]);
        dec_d.funct3 = f3;
        dec_d.funct7 = (is_op || (f3 == FUNCT3_SR)) ? inst_in[31:25] : 7'd0;
        dec_d.rd     = rd;
        dec_d.we     = (rd != '0);
      end else begin
        ill_d = 1'b1;
      end
    end
  end

  // Issue and retire of the same register net to zero, so the bit stays set
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_d[i] = pend_q[i]
                + CNT_W'(issue_we && (rd == REG_AW'(i)))
                - CNT_W'(wb_enable && (wb_dest == REG_AW'(i)) && (pend_q[i] != '0));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dec_q <= '0;
      ill_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= '0;
    end else begin
      dec_q <= dec_d;
      ill_q <= ill_d;
      for (int i = 0; i < NUM_REGS; i++) pend_q[i] <= pend_d[i];
    end
  end

  assign data_source1     = WORD_SIZE'(dec_q.src1);
  assign data_source2     = WORD_SIZE'(dec_q.src2);
  assign funct7           = dec_q.funct7;
  assign funct3           = dec_q.funct3;
  assign reg_dest_out     = dec_q.rd;
  assign write_enable_out = dec_q.we;
  assign illegal_inst     = ill_q;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: directed hazard/reset scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_decode;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] inst_in = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] data_source1, data_source2;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  reg_dest_out;
  logic        write_enable_out, illegal_inst;
  logic [31:0] wb_data = '0;
  logic [4:0]  wb_dest = '0;
  logic        wb_enable = 1'b0;

  always #5 clock = ~clock;

  decode dut (
    .clock            (clock),
    .reset            (reset),
    .inst_in          (inst_in),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .data_source1     (data_source1),
    .data_source2     (data_source2),
    .funct7           (funct7),
    .funct3           (funct3),
    .reg_dest_out     (reg_dest_out),
    .write_enable_out (write_enable_out),
    .illegal_inst     (illegal_inst),
    .wb_data          (wb_data),
    .wb_dest          (wb_dest),
    .wb_enable        (wb_enable)
  );

  localparam logic [6:0] OP  = 7'b0110011;
  localparam logic [6:0] IMM = 7'b0010011;

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] regs [32];
  logic [4:0]  inflight[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] r2,
                                      input logic [4:0] r1, input logic [2:0] f3,
                                      input logic [4:0] rdd, input logic [6:0] opc);
    return {f7, r2, r1, f3, rdd, opc};
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] r, input logic wbe,
                                       input logic [4:0] wbd, input logic [31:0] d);
    if (r == 5'd0) return 32'd0;
    if (wbe && (wbd == r)) return d;
    return regs[r];
  endfunction

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  // One clock of stimulus plus the model's view of what it should produce
  task automatic step(input logic [31:0] ins, input logic v, input logic wbe,
                      input logic [4:0] wbd, input logic [31:0] wbdat, output logic acc);
    logic [4:0] rem[$];
    logic       is_op, is_imm, b1, b2, stall;
    logic [4:0] r1, r2, rdd;
    exp_t       e;
    @(negedge clock);
    reset      = 1'b0;
    inst_in    = ins;
    inst_valid = v;
    wb_enable  = wbe;
    wb_dest    = wbd;
    wb_data    = wbdat;
    is_op  = (ins[6:0] == OP);
    is_imm = (ins[6:0] == IMM);
    r1  = ins[19:15];
    r2  = ins[24:20];
    rdd = ins[11:7];
    rem = inflight;
    if (wbe && (rem.size() > 0) && (rem[0] == wbd)) void'(rem.pop_front());
    b1 = 1'b0;
    b2 = 1'b0;
    foreach (rem[k]) begin
      if ((rem[k] == r1) && (r1 != 5'd0)) b1 = 1'b1;
      if ((rem[k] == r2) && (r2 != 5'd0)) b2 = 1'b1;
    end
    stall = v && (is_op || is_imm) && (b1 || (is_op && b2));
    #1;
    n_checks++;
    if (inst_ready !== !stall) begin
      n_fail++;
      $display("FAIL inst_ready t=%0t got %b expected %b", $time, inst_ready, !stall);
    end
    acc = v && !stall;
    e.s1 = '0; e.s2 = '0; e.f7 = '0; e.f3 = '0; e.rd = '0; e.we = 1'b0; e.ill = 1'b0;
    if (acc && (is_op || is_imm)) begin
      e.s1 = opnd(r1, wbe, wbd, wbdat);
      e.s2 = is_op ? opnd(r2, wbe, wbd, wbdat) : {{20{ins[31]}}, ins[31:20]};
      e.f3 = ins[14:12];
      e.f7 = (is_op || (ins[14:12] == 3'b101)) ? ins[31:25] : 7'd0;
      e.rd = rdd;
      e.we = (rdd != 5'd0);
    end else if (acc) begin
      e.ill = 1'b1;
    end
    if (e.we) rem.push_back(rdd);
    inflight = rem;
    if (wbe && (wbd != 5'd0)) regs[wbd] = wbdat;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [31:0] ins, input logic v);
    exp_t e;
    @(negedge clock);
    reset      = 1'b1;
    inst_in    = ins;
    inst_valid = v;
    wb_enable  = 1'b0;
    e.s1 = '0; e.s2 = '0; e.f7 = '0; e.f3 = '0; e.rd = '0; e.we = 1'b0; e.ill = 1'b0;
    exp_q.push_back(e);
    inflight.delete();
    foreach (regs[i]) regs[i] = '0;
  endtask

  // Monitor: every cycle presents an issue slot (real op or bubble)
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({data_source1, data_source2, funct7, funct3, reg_dest_out, write_enable_out, illegal_inst}
            !== {e.s1, e.s2, e.f7, e.f3, e.rd, e.we, e.ill}) begin
          n_fail++;
          $display("FAIL issue t=%0t got s1=%h s2=%h f7=%h f3=%h rd=%0d we=%b ill=%b expected s1=%h s2=%h f7=%h f3=%h rd=%0d we=%b ill=%b",
                   $time, data_source1, data_source2, funct7, funct3, reg_dest_out,
                   write_enable_out, illegal_inst, e.s1, e.s2, e.f7, e.f3, e.rd, e.we, e.ill);
        end
      end
    end
  end

  initial begin
    logic        a, v, wbe, held_valid;
    logic [4:0]  wbd;
    logic [31:0] wbdat, ins, held, add_i, sub_i;
    logic [6:0]  opc;
    int          sel;

    foreach (regs[i]) regs[i] = '0;
    do_reset(32'd0, 1'b0);
    do_reset(32'd0, 1'b0);

    // ADDI with negative immediate after writing x5
    step(32'd0, 1'b0, 1'b1, 5'd5, 32'h0000_0007, a);
    step(32'hFFF2_8313, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b1, 5'd6, 32'h0000_0011, a);

    // RAW stall resolved by same-cycle writeback bypass
    add_i = enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP);
    sub_i = enc(7'h20, 5'd1, 5'd3, 3'b000, 5'd4, OP);
    step(add_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(sub_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(sub_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(sub_i, 1'b1, 1'b1, 5'd3, 32'h1234_5678, a);
    step(32'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0002, a);

    // SRAI keeps funct7
    step(32'h4033_D393, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b1, 5'd7, 32'h0000_0099, a);

    // Unsupported opcode, then a reader of its rd must not stall
    step(enc(7'h00, 5'd3, 5'd2, 3'b010, 5'd8, 7'b0000011), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(enc(7'h00, 5'd8, 5'd8, 3'b000, 5'd9, OP), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b1, 5'd9, 32'h0000_0005, a);

    // x0 destination and x0 write attempts
    step(enc(7'h00, 5'd2, 5'd1, 3'b000, 5'd0, OP), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b1, 5'd0, 32'h0000_DEAD, a);
    step(enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd10, OP), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(enc(7'h00, 5'd0, 5'd0, 3'b000, 5'd11, OP), 1'b1, 1'b1, 5'd0, 32'h0000_DEAD, a);
    step(32'd0, 1'b0, 1'b1, 5'd10, 32'h0000_00A0, a);
    step(32'd0, 1'b0, 1'b1, 5'd11, 32'h0000_00B0, a);

    // Same-cycle issue and writeback of x12 leaves it busy
    step(enc(7'h00, 5'd0, 5'd1, 3'b000, 5'd12, IMM), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(enc(7'h00, 5'd1, 5'd0, 3'b000, 5'd12, IMM), 1'b1, 1'b1, 5'd12, 32'h0000_0055, a);
    step(enc(7'h00, 5'd0, 5'd12, 3'b000, 5'd13, OP), 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(enc(7'h00, 5'd0, 5'd12, 3'b000, 5'd13, OP), 1'b1, 1'b1, 5'd12, 32'h0000_0066, a);
    step(32'd0, 1'b0, 1'b1, 5'd13, 32'h0000_0077, a);

    // Reset while stalled drops the op and clears the scoreboard
    step(add_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(sub_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    do_reset(sub_i, 1'b1);
    step(sub_i, 1'b1, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b1, 5'd4, 32'h0000_0003, a);

    // Randomized traffic
    held_valid = 1'b0;
    held = '0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(held, held_valid);
        held_valid = 1'b0;
        continue;
      end
      wbe   = 1'b0;
      wbd   = 5'd0;
      wbdat = $urandom;
      if ((inflight.size() > 0) && ((inflight.size() >= 6) || ($urandom_range(0, 1) == 1))) begin
        wbe = 1'b1;
        wbd = inflight[0];
      end else if ($urandom_range(0, 3) == 0) begin
        wbd = 5'($urandom_range(0, 31));
        wbe = 1'b1;
        foreach (inflight[k]) if (inflight[k] == wbd) wbe = 1'b0;
      end
      if (held_valid) begin
        ins = held;
        v   = 1'b1;
      end else begin
        v   = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 9);
        if (sel < 4) opc = OP;
        else if (sel < 8) opc = IMM;
        else begin
          opc = 7'($urandom);
          while ((opc == OP) || (opc == IMM)) opc = 7'($urandom);
        end
        ins = enc(7'($urandom), pick_reg(), pick_reg(), 3'($urandom), pick_reg(), opc);
      end
      step(ins, v, wbe, wbd, wbdat, a);
      held_valid = v && !a;
      held = ins;
    end

    step(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, a);
    step(32'd0, 1'b0, 1'b0, 5'd0, 32'd0, a);
    @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
